// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the pipelined ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH:0]   sum;

  // Low half starts as the multiplier and shifts out one bit per step.
  assign sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_hi = sum[WIDTH:1];
  assign prod_lo = {sum[0], lo_q[WIDTH-1:1]};

  // prod_* show the post-step value, so the final product is ready on the last step.
  assign done    = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
    end else if (start) begin
      cnt_q   <= CW'(WIDTH);
      hi_q    <= '0;
      lo_q    <= b;
      mcand_q <= a;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      hi_q  <= prod_hi;
      lo_q  <= prod_lo;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU with registered result and flags; multiply is iterative when
// ALU_PIPE_MUL_EN is defined, otherwise op 111 is a single-cycle zero result.
//
// state | meaning
// IDLE  | no result held, ready for an operation
// BUSY  | multiply in progress, inputs blocked
// DONE  | result/flags valid, held until consumed
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ZF,
  output logic             SF,
  output logic             OF
);

  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  state_t           state_q, state_d;
  logic             xfer_in;
  logic             is_mul;
  logic             load_alu;
  logic             load_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] alu_r;
  logic             alu_of;
  logic             sat;
  logic [WIDTH-1:0] fin_r;
  logic             fin_of;

  assign xfer_in  = in_valid & in_ready;
  assign load_alu = xfer_in & ~is_mul;

`ifdef ALU_PIPE_MUL_EN
  assign is_mul = (op_code == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (xfer_in & is_mul),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .prod_lo (mul_lo),
    .prod_hi (mul_hi)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_lo   = '0;
  assign mul_hi   = '0;
`endif

  assign sat = (B >= W_VAL);

  always_comb begin
    alu_r  = '0;
    alu_of = 1'b0;
    case (op_code)
      OP_ADD: begin
        alu_r  = A + B;
        alu_of = (A[WIDTH-1] == B[WIDTH-1]) && (alu_r[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r  = A - B;
        alu_of = (A[WIDTH-1] != B[WIDTH-1]) && (alu_r[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: alu_r = A & B;
      OP_OR:  alu_r = A | B;
      OP_ASR: alu_r = sat ? {WIDTH{A[WIDTH-1]}} : WIDTH'($signed(A) >>> B);
      OP_SHL: alu_r = sat ? '0 : (A << B);
      OP_CMP: begin
        alu_r[2] = (A > B);
        alu_r[1] = (A < B);
        alu_r[0] = (A == B);
      end
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_mul  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = is_mul ? BUSY : DONE;
      end
      BUSY: begin
        if (mul_done) begin
          load_mul = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // Consume and accept in the same cycle so back-to-back ops have no bubble.
        if (out_ready) begin
          if (in_valid) state_d = is_mul ? BUSY : DONE;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fin_r  = load_mul ? mul_lo : alu_r;
  assign fin_of = load_mul ? (|mul_hi) : alu_of;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      result  <= '0;
      ZF      <= 1'b0;
      SF      <= 1'b0;
      OF      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_alu || load_mul) begin
        result <= fin_r;
        ZF     <= (fin_r == '0);
        SF     <= fin_r[WIDTH-1];
        OF     <= fin_of;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): vector table plus stall, multiply and reset sequences.
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] op_code;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       ZF, SF, OF;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [2:0] zso;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op_code   (op_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ZF        (ZF),
    .SF        (SF),
    .OF        (OF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid, counting cycles with in_ready low; bounded at 20 cycles.
  task automatic wait_result(output int busy);
    busy = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) break;
      if (!in_ready) busy++;
      step();
    end
  endtask

  int n;

  initial begin
    vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 3'b011};
    vecs[1]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 3'b100};
    vecs[2]  = '{OP_ADD, 8'h80, 8'h80, 8'h00, 3'b101};
    vecs[3]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 3'b100};
    vecs[4]  = '{OP_CMP, 8'h03, 8'h09, 8'h02, 3'b000};
    vecs[5]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 3'b001};
    vecs[6]  = '{OP_SUB, 8'h03, 8'h09, 8'hFA, 3'b010};
    vecs[7]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 3'b000};
    vecs[8]  = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 3'b010};
    vecs[9]  = '{OP_AND, 8'h0F, 8'hF0, 8'h00, 3'b100};
    vecs[10] = '{OP_ASR, 8'h90, 8'h0A, 8'hFF, 3'b010};
    vecs[11] = '{OP_ASR, 8'h90, 8'h02, 8'hE4, 3'b010};
    vecs[12] = '{OP_ASR, 8'h70, 8'h08, 8'h00, 3'b100};
    vecs[13] = '{OP_SHL, 8'h90, 8'h01, 8'h20, 3'b000};
    vecs[14] = '{OP_SHL, 8'h01, 8'h07, 8'h80, 3'b010};
    vecs[15] = '{OP_SHL, 8'hFF, 8'h08, 8'h00, 3'b100};
    vecs[16] = '{OP_CMP, 8'h09, 8'h03, 8'h04, 3'b000};
    vecs[17] = '{OP_CMP, 8'h55, 8'h55, 8'h01, 3'b000};
    vecs[18] = '{OP_CMP, 8'h00, 8'hFF, 8'h02, 3'b000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; op_code = '0;

    #3;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 8'h00);
    check("reset flags", {ZF, SF, OF}, 3'b000);
    step(); step();
    rst_n = 1'b1;
    step();
    check("idle out_valid", out_valid, 0);
    check("idle in_ready", in_ready, 1);

    // Table: each vector is issued while the previous result is consumed (no bubble).
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      check($sformatf("vec%0d in_ready", i), in_ready, 1);
      in_valid = 1'b1; op_code = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
      step();
      check($sformatf("vec%0d out_valid", i), out_valid, 1);
      check($sformatf("vec%0d result", i), result, vecs[i].r);
      check($sformatf("vec%0d flags", i), {ZF, SF, OF}, vecs[i].zso);
    end
    in_valid = 1'b0;
    step();
    check("drain out_valid", out_valid, 0);

`ifdef ALU_PIPE_MUL_EN
    in_valid = 1'b1; op_code = OP_MUL; A = 8'h10; B = 8'h20;
    step();
    in_valid = 1'b0; op_code = OP_ADD; A = 8'hFF; B = 8'hFF;
    wait_result(n);
    check("mul1 busy cycles", n, 8);
    check("mul1 out_valid", out_valid, 1);
    check("mul1 result", result, 8'h00);
    check("mul1 flags", {ZF, SF, OF}, 3'b101);

    in_valid = 1'b1; op_code = OP_MUL; A = 8'h0C; B = 8'h0B;
    step();
    in_valid = 1'b0; op_code = OP_SUB; A = 8'h33; B = 8'h77;
    wait_result(n);
    check("mul2 busy cycles", n, 8);
    check("mul2 out_valid", out_valid, 1);
    check("mul2 result", result, 8'h84);
    check("mul2 flags", {ZF, SF, OF}, 3'b010);
    step();
    check("mul2 drain", out_valid, 0);

    // Reset during the fourth multiply cycle.
    in_valid = 1'b1; op_code = OP_MUL; A = 8'h0C; B = 8'h0B;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    check("mulrst busy in_ready", in_ready, 0);
    check("mulrst held result", result, 8'h84);
    #2 rst_n = 1'b0;
    #1;
    check("mulrst out_valid", out_valid, 0);
    check("mulrst result", result, 8'h00);
    check("mulrst in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      if (out_valid) n++;
      step();
    end
    check("mulrst stale out_valid", n, 0);
    check("mulrst post in_ready", in_ready, 1);
`else
    in_valid = 1'b1; op_code = OP_MUL; A = 8'h10; B = 8'h20;
    step();
    in_valid = 1'b0;
    check("mul_off out_valid", out_valid, 1);
    check("mul_off result", result, 8'h00);
    check("mul_off flags", {ZF, SF, OF}, 3'b100);
    step();
    check("mul_off drain", out_valid, 0);
`endif

    // Output stall: result held, new op blocked until out_ready rises.
    out_ready = 1'b0;
    in_valid = 1'b1; op_code = OP_ADD; A = 8'h12; B = 8'h34;
    step();
    op_code = OP_OR; A = 8'h01; B = 8'h02;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d out_valid", k), out_valid, 1);
      check($sformatf("stall%0d result", k), result, 8'h46);
      check($sformatf("stall%0d flags", k), {ZF, SF, OF}, 3'b000);
      check($sformatf("stall%0d in_ready", k), in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("stall release in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("stall new out_valid", out_valid, 1);
    check("stall new result", result, 8'h03);
    step();
    check("stall drain", out_valid, 0);

    // Reset while a result is held in DONE.
    out_ready = 1'b0;
    in_valid = 1'b1; op_code = OP_ADD; A = 8'h01; B = 8'h01;
    step();
    in_valid = 1'b0;
    check("donerst pre out_valid", out_valid, 1);
    check("donerst pre result", result, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    check("donerst out_valid", out_valid, 0);
    check("donerst result", result, 8'h00);
    check("donerst in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) n++;
      step();
    end
    check("donerst stale out_valid", n, 0);
    check("donerst post in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B, or shift amount.
REQ-008 op_code  input  3  000 add, 001 sub, 010 AND, 011 OR, 100 arith right shift, 101 left shift, 110 compare, 111 multiply.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 ZF, SF, OF  output  1 each  zero, sign (result MSB), signed overflow; registered with result.

Function
REQ-013 FSM states IDLE, BUSY, DONE; transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-014 in_ready = 1 in IDLE, = out_ready in DONE, = 0 in BUSY.
REQ-015 out_valid = 1 exactly in DONE; result/flags held stable in DONE until transfer out.
REQ-016 Single-cycle ops (000-110): transfer in registers result/flags, next state DONE; out_valid rises the following cycle (latency 1).
REQ-017 Multiply (111): transfer in loads operands, next state BUSY; BUSY lasts WIDTH cycles (one shift-add step per cycle); then DONE; latency WIDTH+1 cycles.
REQ-018 DONE with transfer out and simultaneous transfer in: new operation accepted same cycle, no bubble; next state DONE (single-cycle op) or BUSY (multiply).
REQ-019 DONE with transfer out and no transfer in: next state IDLE.
REQ-020 Add/sub: WIDTH-bit wrap-around; OF = two's-complement overflow (add: same-sign operands, result sign differs; sub: differing-sign operands, result sign differs from A).
REQ-021 Shifts: amount = unsigned B; B >= WIDTH saturates (right: all bits = A MSB; left: all zero); OF = 0.
REQ-022 Compare (unsigned): result bit2 = A>B, bit1 = A<B, bit0 = A==B, other bits 0; OF = 0.
REQ-023 Multiply: unsigned; result = low WIDTH bits of product; OF = 1 iff upper WIDTH bits nonzero.
REQ-024 AND/OR: OF = 0; ZF = (result == 0) and SF = result[WIDTH-1] for all ops.
REQ-025 Operand inputs are ignored outside transfer in; changing A/B/op_code during BUSY has no effect.

Reset
REQ-026 rst_n low forces state IDLE, out_valid 0, result 0, ZF 0, SF 0, OF 0, multiply step counter 0, immediately without a clock edge.
REQ-027 Reset asserted mid-multiply or in DONE discards the operation; no out_valid after release until a new transfer in.
REQ-028 in_ready = 1 during and immediately after reset.

Configuration
REQ-029 Macro ALU_PIPE_MUL_EN defined: multiply implemented per REQ-017/023.
REQ-030 Macro ALU_PIPE_MUL_EN undefined: no multiplier logic or BUSY entry; op 111 is single-cycle, result 0, ZF 1, SF 0, OF 0.

Structure
REQ-031 Shared package alu_pkg holds opcode constants (OP_ADD..OP_MUL) and the FSM state enumeration.
REQ-032 Iterative shift-add multiplier in one sub-module alu_mul_iter (start, operands, done, product low/high), instantiated only under ALU_PIPE_MUL_EN.

Verification (WIDTH=8 unless stated)
REQ-033 add A=0x7F B=0x01, out_ready=1 -> one cycle later out_valid, result 0x80, SF 1, OF 1, ZF 0.
REQ-034 sub A=0x05 B=0x05 then compare A=0x03 B=0x09 back-to-back with out_ready=1 -> results 0x00 (ZF 1) then 0x02 on consecutive cycles, no bubble.
REQ-035 shift right A=0x90 B=0x0A -> 0xFF; shift left A=0x90 B=0x01 -> 0x20, OF 0.
REQ-036 multiply A=0x10 B=0x20 (macro defined) -> in_ready 0 for 8 cycles, result 0x00, OF 1, ZF 1; A=0x0C B=0x0B -> 0x84, OF 0.
REQ-037 out_ready held 0 for 5 cycles after a result -> result/flags stable, in_ready 0, new in_valid not accepted until out_ready rises.
REQ-038 rst_n pulsed low during multiply cycle 4 -> out_valid 0, result 0 immediately; after release in_ready 1, no stale result emitted.
